// File: rtl/shift_add_multiplier.sv
// Sequential 16x16 shift-and-add multiplier (product mod 2^16) that drives an external
// barrel_shifter16 and accumulates one shifted partial product per set multiplier bit.
module shift_add_multiplier #(
  parameter int W          = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sh_in,
  output logic [3:0]   sh_s,
  input  logic [W-1:0] sh_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic [1:0]   state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
  // The producer holds data stable while valid=1 and ready=0; ready never depends on valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] acc;
  logic [3:0]   k;

  logic [W-1:0] b_above;
  logic         last_scan;
  logic [W-1:0] acc_next;

  // Bits of b strictly above k; shifted in two steps so k==15 never overflows k+1.
  always_comb begin
    b_above   = (b_r >> k) >> 1;
    last_scan = (k == 4'd15) || (EARLY_EXIT && (b_above == '0));
    acc_next  = b_r[k] ? (acc + sh_out) : acc;
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign sh_in     = a_r;
  assign sh_s      = (state == SCAN) ? k : 4'd0;
  assign product   = acc;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      k         <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            k     <= 4'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          // The exiting cycle's partial product is still folded into acc.
          acc <= acc_next;
          if (last_scan) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            k <= k + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: early-exit and full-scan instances run in lockstep
// against an arithmetic reference model, with directed cases followed by random operands.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;

  logic        in_ready_e, out_valid_e, in_ready_f, out_valid_f;
  logic [15:0] sh_in_e, sh_out_e, product_e, sh_in_f, sh_out_f, product_f;
  logic [3:0]  sh_s_e, sh_s_f;
  logic [1:0]  state_e, state_f;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Behavioural barrel_shifter16 for each instance.
  assign sh_out_e = sh_in_e << sh_s_e;
  assign sh_out_f = sh_in_f << sh_s_f;

  shift_add_multiplier #(.W(16), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e),
    .a(a), .b(b), .sh_in(sh_in_e), .sh_s(sh_s_e), .sh_out(sh_out_e),
    .out_valid(out_valid_e), .out_ready(out_ready), .product(product_e),
    .state_dbg(state_e)
  );

  shift_add_multiplier #(.W(16), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
    .a(a), .b(b), .sh_in(sh_in_f), .sh_s(sh_s_f), .sh_out(sh_out_f),
    .out_valid(out_valid_f), .out_ready(out_ready), .product(product_f),
    .state_dbg(state_f)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_mul(input logic [15:0] av, input logic [15:0] bv);
    logic [31:0] p;
    p = {16'h0, av} * {16'h0, bv};
    return p[15:0];
  endfunction

  function automatic int ref_scan(input logic [15:0] bv, input bit early);
    if (!early) return 16;
    for (int i = 15; i >= 0; i--) if (bv[i]) return i + 1;
    return 1;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
    int guard = 0;
    while (!(in_ready_e && in_ready_f) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", {30'b0, in_ready_e, in_ready_f}, 32'd3);
    a = av;
    b = bv;
    in_valid = 1'b1;
    exp_q.push_back(ref_mul(av, bv));
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    check("in_ready_scan", {30'b0, in_ready_e, in_ready_f}, 32'd0);
  endtask

  task automatic wait_done(input logic [15:0] av, input logic [15:0] bv);
    int n_e = 0;
    int n_f = 0;
    int guard = 0;
    bit seq_ok = 1'b1;
    while (!(out_valid_e && out_valid_f) && guard < 40) begin
      if (!out_valid_e) begin
        if (sh_s_e !== 4'(n_e)) seq_ok = 1'b0;
        n_e++;
      end
      if (!out_valid_f) n_f++;
      guard++;
      @(negedge clk);
    end
    check("scan_cycles_early", n_e, ref_scan(bv, 1'b1));
    check("scan_cycles_full", n_f, ref_scan(bv, 1'b0));
    check("sh_s_sequence", {31'b0, seq_ok}, 32'd1);
    check("sh_in_operand", sh_in_e, av);
    check("sh_s_done_zero", sh_s_e, 32'd0);
    if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    check("product_early", product_e, last_exp);
    check("product_full", product_f, last_exp);
  endtask

  task automatic finish_op(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      check("hold_valid", {30'b0, out_valid_e, out_valid_f}, 32'd3);
      check("hold_product", product_e, last_exp);
      check("hold_in_ready", {30'b0, in_ready_e, in_ready_f}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", {30'b0, out_valid_e, out_valid_f}, 32'd0);
    check("post_hs_in_ready", {30'b0, in_ready_e, in_ready_f}, 32'd3);
    check("idle_product_held", product_f, last_exp);
  endtask

  task automatic op(input logic [15:0] av, input logic [15:0] bv, input int hold);
    start_op(av, bv);
    wait_done(av, bv);
    finish_op(hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {30'b0, out_valid_e, out_valid_f}, 32'd0);
    check({tag, "_in_ready"}, {30'b0, in_ready_e, in_ready_f}, 32'd0);
    check({tag, "_product"}, product_e | product_f, 32'd0);
    check({tag, "_sh"}, {sh_in_e, sh_s_e}, 32'd0);
    check({tag, "_state"}, {state_e, state_f}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra, rb;
    int guard;

    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", {30'b0, in_ready_e, in_ready_f}, 32'd3);

    op(16'h0003, 16'h0005, 0);
    check("t1_constant", product_e, 32'h000F);
    op(16'h1234, 16'h0000, 0);
    op(16'hFFFF, 16'hFFFF, 1);
    check("t3_constant", product_e, 32'h0001);
    op(16'h0001, 16'h8000, 0);
    op(16'h0001, 16'h0001, 0);
    op(16'h00AB, 16'h0010, 5);

    // Reset while scanning at k=7.
    start_op(16'h5555, 16'hFFFF);
    guard = 0;
    while (sh_s_e != 4'd7 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("k7_reached", sh_s_e, 32'd7);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_scan");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    op(16'h0007, 16'h0006, 0);
    check("t6_constant", product_e, 32'h002A);

    // Reset while a product is waiting in DONE.
    start_op(16'h0009, 16'h0009);
    wait_done(16'h0009, 16'h0009);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_done");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) & 16'((32'd1 << $urandom_range(0, 16)) - 32'd1);
      op(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
